// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI frame-level register controller.
//   state_t      : controller FSM states
//   CMD_*_BIT    : bit positions inside the command byte
//   TX_IDLE_BYTE : byte presented to the SPI reader when no read is in progress
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_INC_BIT   = 6;

    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_frame_timer.sv
// Inactivity timer that recovers frame boundaries on a link with no chip select.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-low reset
//   clear   : restart the count (a byte was received)
//   enable  : count while a frame is open; the count is held at zero otherwise
//   expired : high during the cycle in which the count sits at TIMEOUT_CYCLES-1
module spi_frame_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear || !enable) begin
            count_reg <= '0;
        end else if (count_reg != LAST_COUNT) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/spi_register_controller.sv
// Frame-level controller behind the byte-oriented SPI reader. Decodes the first
// byte of each frame as a command and then performs single or burst writes /
// reads against an external register bank with a one-cycle synchronous read.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   rx_data       : received byte, qualified by the one-cycle rx_valid pulse
//   tx_data       : byte offered to the SPI reader for the next transfer
//   reg_wr_en     : one-cycle write strobe with reg_addr / reg_wr_data
//   reg_addr      : register address for both reads and writes
//   reg_rd_data   : register read data, valid one cycle after reg_addr changes
//   frame_active  : high while a frame is open
//   error         : sticky flag for a command with an out-of-range address
module spi_register_controller
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    input  logic [7:0]        reg_rd_data,
    output logic              frame_active,
    output logic              error
);

    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              inc_reg, inc_next;
    logic              wr_en_reg, wr_en_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic [7:0]        tx_reg, tx_next;
    logic              error_reg, error_next;
    // Read fetch pipeline: bit0 = address just loaded, bit1 = read data valid now.
    logic [1:0]        fetch_reg, fetch_next;

    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_addr_ok;
    logic              timer_expired;
    logic              unused_cmd_bits;

    assign cmd_addr        = rx_data[ADDR_W-1:0];
    assign cmd_addr_ok     = ({1'b0, cmd_addr} < NUM_REGS_L);
    // Command bits between the address field and bit 6 carry no meaning.
    assign unused_cmd_bits = ^rx_data;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    spi_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (state_reg != IDLE),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            inc_reg     <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
            tx_reg      <= TX_IDLE_BYTE;
            error_reg   <= 1'b0;
            fetch_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            inc_reg     <= inc_next;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= wr_data_next;
            tx_reg      <= tx_next;
            error_reg   <= error_next;
            fetch_reg   <= fetch_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        inc_next     = inc_reg;
        wr_en_next   = 1'b0;
        wr_data_next = wr_data_reg;
        tx_next      = tx_reg;
        error_next   = error_reg;
        fetch_next   = {fetch_reg[0], 1'b0};

        // Burst writes step the address in the cycle after the strobe so the
        // strobe itself always carries the address the byte was meant for.
        if (wr_en_reg && inc_reg) begin
            addr_next = wrap_inc(addr_reg);
        end

        if (state_reg == READ && fetch_reg[1]) begin
            tx_next = reg_rd_data;
        end

        unique case (state_reg)
            IDLE: begin
                tx_next = TX_IDLE_BYTE;
                if (rx_valid) begin
                    inc_next = rx_data[CMD_INC_BIT];
                    if (!cmd_addr_ok) begin
                        state_next = DISCARD;
                        error_next = 1'b1;
                    end else if (rx_data[CMD_WRITE_BIT]) begin
                        state_next = WRITE;
                        addr_next  = cmd_addr;
                    end else begin
                        state_next    = READ;
                        addr_next     = cmd_addr;
                        fetch_next[0] = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (rx_valid) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = rx_data;
                end else if (timer_expired) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (rx_valid) begin
                    if (inc_reg) begin
                        addr_next = wrap_inc(addr_reg);
                    end
                    fetch_next[0] = 1'b1;
                end else if (timer_expired) begin
                    state_next = IDLE;
                    tx_next    = TX_IDLE_BYTE;
                    fetch_next = '0;
                end
            end
            DISCARD: begin
                if (!rx_valid && timer_expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_data      = tx_reg;
    assign reg_wr_en    = wr_en_reg;
    assign reg_addr     = addr_reg;
    assign reg_wr_data  = wr_data_reg;
    assign frame_active = (state_reg != IDLE);
    assign error        = error_reg;

endmodule

// File: tb/tb_spi_register_controller.sv
// Drives two controllers (16 and 12 registers) with the same byte stream and
// checks them against a frame-level reference model plus a directed table.
module tb_spi_register_controller;

    localparam int TO = 16;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       env_load = 1'b1;

    logic [7:0]    tx_data      [2];
    logic          reg_wr_en    [2];
    logic [AW-1:0] reg_addr     [2];
    logic [7:0]    reg_wr_data  [2];
    logic [7:0]    reg_rd_data  [2];
    logic          frame_active [2];
    logic          error        [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        spi_register_controller #(
            .NUM_REGS      (gi == 0 ? 16 : 12),
            .ADDR_W        (AW),
            .TIMEOUT_CYCLES(TO)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .rx_data     (rx_data),
            .rx_valid    (rx_valid),
            .tx_data     (tx_data[gi]),
            .reg_wr_en   (reg_wr_en[gi]),
            .reg_addr    (reg_addr[gi]),
            .reg_wr_data (reg_wr_data[gi]),
            .reg_rd_data (reg_rd_data[gi]),
            .frame_active(frame_active[gi]),
            .error       (error[gi])
        );
    end

    // Register bank environment with registered read, plus strobe counters.
    logic [7:0] init_mem [2][16];
    logic [7:0] env_mem  [2][16];
    int         wr_count [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (env_load) begin
                for (int k = 0; k < 16; k++) env_mem[d][k] <= init_mem[d][k];
                wr_count[d] <= 0;
            end else if (reg_wr_en[d]) begin
                env_mem[d][reg_addr[d]] <= reg_wr_data[d];
                wr_count[d] <= wr_count[d] + 1;
            end
            reg_rd_data[d] <= env_mem[d][reg_addr[d]];
        end
    end

    // Frame-level reference model: 0 idle, 1 write, 2 read, 3 discard.
    int         num_r  [2] = '{16, 12};
    int         m_mode [2];
    logic [3:0] m_addr [2];
    bit         m_inc  [2];
    bit         m_err  [2];
    int         m_wr   [2];
    logic [7:0] m_mem  [2][16];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
        end
    endtask

    function automatic logic [3:0] m_next(input int d, input logic [3:0] a);
        return (int'(a) == num_r[d] - 1) ? 4'd0 : a + 4'd1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_addr[d] = 4'd0; m_inc[d] = 1'b0; m_err[d] = 1'b0;
        end
    endtask

    // Applies one received byte to the model; returns the strobe expected in the
    // following cycle and the tx byte expected three cycles after the byte.
    task automatic model_byte(input int d, input logic [7:0] b, output bit ew,
                              output logic [3:0] ea, output logic [7:0] etx);
        ew  = 1'b0;
        etx = 8'hFF;
        case (m_mode[d])
            0: begin
                m_inc[d] = b[6];
                if (int'(b[3:0]) >= num_r[d]) begin
                    m_mode[d] = 3;
                    m_err[d]  = 1'b1;
                end else begin
                    m_addr[d] = b[3:0];
                    m_mode[d] = b[7] ? 1 : 2;
                    if (!b[7]) etx = m_mem[d][m_addr[d]];
                end
                ea = m_addr[d];
            end
            1: begin
                ew = 1'b1;
                ea = m_addr[d];
                m_mem[d][m_addr[d]] = b;
                m_wr[d]++;
                if (m_inc[d]) m_addr[d] = m_next(d, m_addr[d]);
            end
            2: begin
                if (m_inc[d]) m_addr[d] = m_next(d, m_addr[d]);
                ea  = m_addr[d];
                etx = m_mem[d][m_addr[d]];
            end
            default: ea = m_addr[d];
        endcase
    endtask

    // Sends one byte and checks both DUTs; returns what DUT0 (and DUT1 error) showed.
    task automatic send_byte(input logic [7:0] b, output logic o_wr, output logic [3:0] o_addr,
                             output logic [7:0] o_data, output logic [7:0] o_tx, output logic o_err1);
        bit         ew  [2];
        logic [3:0] ea  [2];
        logic [7:0] etx [2];
        for (int d = 0; d < 2; d++) model_byte(d, b, ew[d], ea[d], etx[d]);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        o_wr   = reg_wr_en[0];
        o_addr = reg_addr[0];
        o_data = reg_wr_data[0];
        o_err1 = error[1];
        for (int d = 0; d < 2; d++) begin
            chk("wr_en", d, reg_wr_en[d], ew[d]);
            chk("reg_addr", d, reg_addr[d], ea[d]);
            if (ew[d]) chk("wr_data", d, reg_wr_data[d], b);
            chk("error", d, error[d], m_err[d]);
            chk("frame_active", d, frame_active[d], 1);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("wr_en_single", d, reg_wr_en[d], 0);
        @(negedge clk);
        o_tx = tx_data[0];
        for (int d = 0; d < 2; d++) chk("tx_data", d, tx_data[d], etx[d]);
    endtask

    task automatic send(input logic [7:0] b);
        logic w, e; logic [3:0] a; logic [7:0] dt, tx;
        send_byte(b, w, a, dt, tx, e);
    endtask

    // Called right after send_byte: checks the frame closes exactly TO cycles after the last byte.
    task automatic end_frame();
        repeat (TO - 3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("active_before_timeout", d, frame_active[d], 1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("active_after_timeout", d, frame_active[d], 0);
            chk("tx_after_timeout", d, tx_data[d], 8'hFF);
            chk("strobe_count", d, wr_count[d], m_wr[d]);
            m_mode[d] = 0;
        end
    endtask

    // Reset asserted together with a byte in the middle of a frame.
    task automatic reset_mid();
        @(negedge clk);
        rst      = 1'b0;
        rx_data  = 8'h20;
        rx_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_wr_en", d, reg_wr_en[d], 0);
            chk("rst_tx", d, tx_data[d], 8'hFF);
            chk("rst_active", d, frame_active[d], 0);
            chk("rst_error", d, error[d], 0);
            chk("rst_addr", d, reg_addr[d], 0);
            chk("rst_wr_data", d, reg_wr_data[d], 0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_no_strobe", d, reg_wr_en[d], 0);
            chk("rst_strobe_count", d, wr_count[d], m_wr[d]);
        end
    endtask

    typedef struct {
        bit         last;
        logic [7:0] b;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] tx;
        logic       err1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic       o_wr, o_err1;
        logic [3:0] o_addr;
        logic [7:0] o_data, o_tx, cmd;
        int         len;

        tbl[0]  = '{1'b0, 8'h42, 1'b0, 4'd2,  8'h00, 8'hA5, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 4'd3,  8'h00, 8'h3C, 1'b0};
        tbl[2]  = '{1'b0, 8'h83, 1'b0, 4'd3,  8'h00, 8'hFF, 1'b0};
        tbl[3]  = '{1'b1, 8'h5A, 1'b1, 4'd3,  8'h5A, 8'hFF, 1'b0};
        tbl[4]  = '{1'b0, 8'hCE, 1'b0, 4'd14, 8'h00, 8'hFF, 1'b1};
        tbl[5]  = '{1'b0, 8'h11, 1'b1, 4'd14, 8'h11, 8'hFF, 1'b1};
        tbl[6]  = '{1'b0, 8'h22, 1'b1, 4'd15, 8'h22, 8'hFF, 1'b1};
        tbl[7]  = '{1'b1, 8'h33, 1'b1, 4'd0,  8'h33, 8'hFF, 1'b1};
        tbl[8]  = '{1'b0, 8'h8D, 1'b0, 4'd13, 8'h00, 8'hFF, 1'b1};
        tbl[9]  = '{1'b1, 8'h77, 1'b1, 4'd13, 8'h77, 8'hFF, 1'b1};
        tbl[10] = '{1'b0, 8'h81, 1'b0, 4'd1,  8'h00, 8'hFF, 1'b1};
        tbl[11] = '{1'b1, 8'h01, 1'b1, 4'd1,  8'h01, 8'hFF, 1'b1};

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) init_mem[d][k] = 8'($urandom_range(0, 254));
            init_mem[d][2] = 8'hA5;
            init_mem[d][3] = 8'h3C;
            for (int k = 0; k < 16; k++) m_mem[d][k] = init_mem[d][k];
            m_wr[d] = 0;
        end
        model_reset();

        // Reset state and quiet period after release.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_tx", d, tx_data[d], 8'hFF);
            chk("reset_active", d, frame_active[d], 0);
            chk("reset_error", d, error[d], 0);
            chk("reset_addr", d, reg_addr[d], 0);
            chk("reset_wr_data", d, reg_wr_data[d], 0);
        end
        rst      = 1'b1;
        env_load = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("idle_wr_en", d, reg_wr_en[d], 0);
                chk("idle_tx", d, tx_data[d], 8'hFF);
                chk("idle_active", d, frame_active[d], 0);
            end
        end

        // Directed frames from the table (DUT0 values, DUT1 error flag).
        for (int i = 0; i < 12; i++) begin
            send_byte(tbl[i].b, o_wr, o_addr, o_data, o_tx, o_err1);
            $display("vec %0d byte=%02h wr=%0b addr=%0d data=%02h tx=%02h err1=%0b",
                     i, tbl[i].b, o_wr, o_addr, o_data, o_tx, o_err1);
            chk("tbl_wr_en", 0, o_wr, tbl[i].wr);
            chk("tbl_addr", 0, o_addr, tbl[i].addr);
            if (tbl[i].wr) chk("tbl_wr_data", 0, o_data, tbl[i].data);
            chk("tbl_tx", 0, o_tx, tbl[i].tx);
            chk("tbl_err_sticky", 1, o_err1, tbl[i].err1);
            if (tbl[i].last) end_frame();
        end

        // Byte arriving on the exact expiry cycle keeps the frame open.
        send(8'h85);
        repeat (TO - 4) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pre_expiry_active", d, frame_active[d], 1);
        send(8'h99);
        $display("expiry byte: dut0 addr5=%02h", env_mem[0][5]);
        end_frame();

        // Reset in the middle of a read frame and of a write burst.
        send(8'h40);
        send(8'h00);
        reset_mid();
        $display("reset during read frame done");
        send(8'hC0);
        send(8'h10);
        reset_mid();
        $display("reset during write burst done");

        // Randomized frames against the reference model.
        for (int f = 0; f < 30; f++) begin
            cmd = 8'($urandom);
            len = $urandom_range(0, 4);
            send(cmd);
            for (int k = 0; k < len; k++) send(8'($urandom));
            end_frame();
            $display("random frame %0d cmd=%02h len=%0d", f, cmd, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_register_controller.md
# spi_register_controller

Frame-level controller sequencing the byte-oriented `SPIReader`: consumes its received bytes, decodes command frames, and issues single or burst writes and reads against a register bank. It sits between the SPI reader (`data`/`received` in, `toOutput` out) and the design's configuration registers. Frame boundaries are recovered from clock-domain inactivity, since the link carries no chip select.

## Interface
- `NUM_REGS`, 16: number of addressable registers; must be ≤ 2^`ADDR_W`.
- `ADDR_W`, 4: register address width; ≤ 6.
- `TIMEOUT_CYCLES`, 1024: `clk` cycles without `rx_valid` that end a frame; must be ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  byte from `SPIReader.data`.
- `rx_valid`  in  1  one-cycle pulse from `SPIReader.received`.
- `tx_data`  out  8  byte to `SPIReader.toOutput`.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_addr`  out  `ADDR_W`  register address, for both read and write.
- `reg_wr_data`  out  8  write data.
- `reg_rd_data`  in  8  read data; synchronous, valid one cycle after `reg_addr` changes.
- `frame_active`  out  1  high while not in IDLE.
- `error`  out  1  sticky; set on an out-of-range address.

## Operation
- Command byte, first byte of a frame:
  - bit7: 1 = write, 0 = read.
  - bit6: auto-increment.
  - bits[`ADDR_W`-1:0]: start address.
  - Remaining bits are ignored.
- States:
  - IDLE → WRITE when the command has bit7=1 and a valid address.
  - IDLE → READ when the command has bit7=0 and a valid address.
  - IDLE → DISCARD when address ≥ `NUM_REGS`; also sets `error`.
  - All non-IDLE states → IDLE on timeout.
- WRITE: each `rx_valid` byte causes:
  - `reg_wr_en`=1 for one cycle, with `reg_wr_data`=byte at the current `reg_addr`.
  - If auto-increment is set, the address increments afterwards. Otherwise subsequent bytes rewrite the same address.
- READ:
  - On command accept, `reg_addr` is loaded and the fetched value is placed on `tx_data`.
  - Each subsequent `rx_valid` (dummy byte) advances the address if auto-increment is set, then reloads `tx_data` with the new register value.
  - Received bytes are otherwise ignored.
- DISCARD: all bytes are ignored; no strobes are issued.
- Address wraps `NUM_REGS`-1 → 0 on increment.
- `tx_data`:
  - Equals 8'hFF in IDLE and DISCARD.
  - Returns to 8'hFF on the cycle after entering IDLE.
- `error` clears only on reset.

## Timing
- Reset (`rst`=0 at a rising edge) forces:
  - state=IDLE, timer=0, `reg_addr`=0.
  - `reg_wr_en`=0, `reg_wr_data`=0, `tx_data`=8'hFF.
  - `frame_active`=0, `error`=0.
- Reset mid-frame aborts the frame; no partial strobe is issued.
- `rx_valid` at cycle N in WRITE: `reg_wr_en` high during N+1; incremented `reg_addr` visible at N+2.
- `rx_valid` at cycle N with a read command, or a dummy byte in READ:
  - `reg_addr` updated at N+1.
  - `reg_rd_data` sampled at the end of N+2.
  - `tx_data` valid from N+3.
- The SPI master must leave ≥ 3 `clk` cycles between the last `received` pulse and the first `spi_clk` edge of the next byte.
- Timer:
  - Clears on every `rx_valid`.
  - Counts in non-IDLE states.
  - On reaching `TIMEOUT_CYCLES`-1 without `rx_valid`, state → IDLE on the next edge.
- Simultaneous `rx_valid` and timer expiry: the byte wins. It is processed in the current state and the timer clears.
- `rx_valid` pulses wider than one cycle are not supported; each high cycle counts as a byte.

## Structure
- Package `spi_ctrl_pkg`:
  - State enum (IDLE, WRITE, READ, DISCARD).
  - Command bit positions `CMD_WRITE_BIT`=7, `CMD_INC_BIT`=6.
  - `TX_IDLE_BYTE`=8'hFF.
- Sub-module `spi_frame_timer`:
  - Ports: `clk`, `rst`, `clear`, `enable`, `expired`.
  - Parameterised by `TIMEOUT_CYCLES`.
- FSM, address counter and tx register live in the top module.

## Test plan
- Reset release → `tx_data`=8'hFF, `frame_active`=0, `error`=0, no `reg_wr_en` for 20 cycles.
- Bytes 0x83, 0x5A → one `reg_wr_en` with `reg_addr`=3, `reg_wr_data`=0x5A; after `TIMEOUT_CYCLES`, `frame_active`=0.
- Burst write 0xCE, 0x11, 0x22, 0x33 (`NUM_REGS`=16) → writes at addresses 14, 15, 0 (wrap) with data 0x11, 0x22, 0x33.
- Register model holds 0xA5 at address 2 and 0x3C at address 3; bytes 0x42, 0x00 → `tx_data`=0xA5 from 3 cycles after the first `rx_valid`, 0x3C after the second; 8'hFF after timeout.
- `NUM_REGS`=12, byte 0x8D → `error`=1 and stays set; following byte 0x77 produces no `reg_wr_en`; a later valid frame 0x81, 0x01 still writes.
- `rx_valid` on the exact expiry cycle keeps the frame open; `rst`=0 mid-burst → IDLE, `tx_data`=8'hFF at the next edge.
